// File: rtl/id_stage_pipe_if.sv
// IF -> ID -> EX bundle for id_stage_pipe: fetch input, regfile ports, EX/MEM writer info, ID/EX outputs.
interface id_stage_pipe_if #(
  parameter int unsigned DATA_W   = 32,
  parameter int unsigned REG_AW   = 5,
  parameter int unsigned STALL_CW = 16
);
  logic                if_valid_i;
  logic [DATA_W-1:0]   pc_i;
  logic [31:0]         inst_i;
  logic                id_ready_o;
  logic [REG_AW-1:0]   reg1_addr_o;
  logic [REG_AW-1:0]   reg2_addr_o;
  logic [DATA_W-1:0]   reg1_data_i;
  logic [DATA_W-1:0]   reg2_data_i;
  logic                ex_wreg_i;
  logic [REG_AW-1:0]   ex_wd_i;
  logic [DATA_W-1:0]   ex_wdata_i;
  logic                ex_is_load_i;
  logic                mem_wreg_i;
  logic [REG_AW-1:0]   mem_wd_i;
  logic [DATA_W-1:0]   mem_wdata_i;
  logic                flush_i;
  logic                ex_valid_o;
  logic                ex_ready_i;
  logic [7:0]          aluop_o;
  logic [2:0]          alusel_o;
  logic [REG_AW-1:0]   wd_o;
  logic                wreg_o;
  logic [DATA_W-1:0]   reg1_o;
  logic [DATA_W-1:0]   reg2_o;
  logic [DATA_W-1:0]   pc_o;
  logic                illegal_o;
  logic [STALL_CW-1:0] stall_cnt_o;

  modport master (
    output if_valid_i, pc_i, inst_i, reg1_data_i, reg2_data_i,
           ex_wreg_i, ex_wd_i, ex_wdata_i, ex_is_load_i,
           mem_wreg_i, mem_wd_i, mem_wdata_i, flush_i, ex_ready_i,
    input  id_ready_o, reg1_addr_o, reg2_addr_o, ex_valid_o,
           aluop_o, alusel_o, wd_o, wreg_o, reg1_o, reg2_o, pc_o,
           illegal_o, stall_cnt_o
  );

  modport slave (
    input  if_valid_i, pc_i, inst_i, reg1_data_i, reg2_data_i,
           ex_wreg_i, ex_wd_i, ex_wdata_i, ex_is_load_i,
           mem_wreg_i, mem_wd_i, mem_wdata_i, flush_i, ex_ready_i,
    output id_ready_o, reg1_addr_o, reg2_addr_o, ex_valid_o,
           aluop_o, alusel_o, wd_o, wreg_o, reg1_o, reg2_o, pc_o,
           illegal_o, stall_cnt_o
  );
endinterface

// File: rtl/id_stage_pipe.sv
// Pipelined MIPS decode stage with RAW hazard handling and a registered ID/EX stage.
// Define ID_FORWARD_EN to forward EX/MEM results and stall only on load-use.
module id_stage_pipe #(
  parameter int unsigned DATA_W   = 32,
  parameter int unsigned REG_AW   = 5,
  parameter int unsigned STALL_CW = 16
) (
  input logic          clk,
  input logic          rst_n,
  id_stage_pipe_if.slave bus
);

  localparam logic [5:0] OP_SPECIAL = 6'h00;
  localparam logic [5:0] OP_ANDI    = 6'h0C;
  localparam logic [5:0] OP_ORI     = 6'h0D;
  localparam logic [5:0] OP_XORI    = 6'h0E;
  localparam logic [5:0] OP_LUI     = 6'h0F;

  localparam logic [5:0] FN_SLL  = 6'h00;
  localparam logic [5:0] FN_SRL  = 6'h02;
  localparam logic [5:0] FN_SRA  = 6'h03;
  localparam logic [5:0] FN_ADDU = 6'h21;
  localparam logic [5:0] FN_SUBU = 6'h23;
  localparam logic [5:0] FN_AND  = 6'h24;
  localparam logic [5:0] FN_OR   = 6'h25;
  localparam logic [5:0] FN_XOR  = 6'h26;
  localparam logic [5:0] FN_NOR  = 6'h27;

  localparam logic [2:0] SEL_NOP   = 3'd0;
  localparam logic [2:0] SEL_LOGIC = 3'd1;
  localparam logic [2:0] SEL_SHIFT = 3'd2;
  localparam logic [2:0] SEL_ARITH = 3'd3;

  logic [5:0]        op, funct;
  logic [REG_AW-1:0] rs, rt, rd;
  logic [4:0]        sa;
  logic [15:0]       imm;

  assign op    = bus.inst_i[31:26];
  assign rs    = REG_AW'(bus.inst_i[25:21]);
  assign rt    = REG_AW'(bus.inst_i[20:16]);
  assign rd    = REG_AW'(bus.inst_i[15:11]);
  assign sa    = bus.inst_i[10:6];
  assign imm   = bus.inst_i[15:0];
  assign funct = bus.inst_i[5:0];

  logic [7:0]        dec_aluop;
  logic [2:0]        dec_alusel;
  logic [REG_AW-1:0] dec_wd;
  logic              dec_wreg, dec_illegal;
  logic              use1, use2, op1_is_sa, op2_is_imm;
  logic [DATA_W-1:0] imm_val;

  // Instruction decode
  always_comb begin
    dec_aluop   = 8'h00;
    dec_alusel  = SEL_NOP;
    dec_wd      = '0;
    dec_wreg    = 1'b0;
    dec_illegal = 1'b0;
    use1        = 1'b0;
    use2        = 1'b0;
    op1_is_sa   = 1'b0;
    op2_is_imm  = 1'b0;
    imm_val     = '0;
    case (op)
      OP_ORI, OP_ANDI, OP_XORI: begin
        dec_wd     = rt;
        dec_wreg   = 1'b1;
        dec_alusel = SEL_LOGIC;
        use1       = 1'b1;
        op2_is_imm = 1'b1;
        imm_val    = DATA_W'(imm);
        dec_aluop  = (op == OP_ORI) ? 8'h25 : ((op == OP_ANDI) ? 8'h24 : 8'h26);
      end
      OP_LUI: begin
        dec_wd     = rt;
        dec_wreg   = 1'b1;
        dec_alusel = SEL_LOGIC;
        dec_aluop  = 8'h25;
        op2_is_imm = 1'b1;
        imm_val    = DATA_W'({imm, 16'h0000});
      end
      OP_SPECIAL: begin
        dec_wd    = rd;
        dec_wreg  = 1'b1;
        dec_aluop = 8'(funct);
        case (funct)
          FN_AND, FN_OR, FN_XOR, FN_NOR: begin
            dec_alusel = SEL_LOGIC;
            use1       = 1'b1;
            use2       = 1'b1;
          end
          FN_ADDU, FN_SUBU: begin
            dec_alusel = SEL_ARITH;
            use1       = 1'b1;
            use2       = 1'b1;
          end
          FN_SLL, FN_SRL, FN_SRA: begin
            dec_alusel = SEL_SHIFT;
            use2       = 1'b1;
            op1_is_sa  = 1'b1;
          end
          default: begin
            dec_wd      = '0;
            dec_wreg    = 1'b0;
            dec_aluop   = 8'h00;
            dec_illegal = 1'b1;
          end
        endcase
      end
      default: dec_illegal = 1'b1;
    endcase
  end

  assign bus.reg1_addr_o = use1 ? rs : '0;
  assign bus.reg2_addr_o = use2 ? rt : '0;

  logic ex_hit1, ex_hit2, mem_hit1, mem_hit2;
  assign ex_hit1  = use1 && (rs != '0) && bus.ex_wreg_i  && (bus.ex_wd_i  == rs);
  assign ex_hit2  = use2 && (rt != '0) && bus.ex_wreg_i  && (bus.ex_wd_i  == rt);
  assign mem_hit1 = use1 && (rs != '0) && bus.mem_wreg_i && (bus.mem_wd_i == rs);
  assign mem_hit2 = use2 && (rt != '0) && bus.mem_wreg_i && (bus.mem_wd_i == rt);

  logic              stall;
  logic [DATA_W-1:0] src1_val, src2_val;

`ifdef ID_FORWARD_EN
  // Only a load still in EX has no value yet; everything else is forwarded
  assign stall    = bus.ex_is_load_i && (ex_hit1 || ex_hit2);
  assign src1_val = ex_hit1 ? bus.ex_wdata_i : (mem_hit1 ? bus.mem_wdata_i : bus.reg1_data_i);
  assign src2_val = ex_hit2 ? bus.ex_wdata_i : (mem_hit2 ? bus.mem_wdata_i : bus.reg2_data_i);
`else
  assign stall    = ex_hit1 || ex_hit2 || mem_hit1 || mem_hit2;
  assign src1_val = bus.reg1_data_i;
  assign src2_val = bus.reg2_data_i;

  logic unused_fwd;
  assign unused_fwd = ^{bus.ex_is_load_i, bus.ex_wdata_i, bus.mem_wdata_i};
`endif

  logic [DATA_W-1:0] op1, op2;
  assign op1 = op1_is_sa ? DATA_W'(sa) : (use1 ? src1_val : '0);
  assign op2 = op2_is_imm ? imm_val : (use2 ? src2_val : '0);

  logic ex_valid_q, advance, accept, cnt_inc;
  assign advance        = !ex_valid_q || bus.ex_ready_i;
  assign bus.id_ready_o = advance && !stall && !bus.flush_i;
  assign accept         = bus.if_valid_i && bus.id_ready_o;
  assign cnt_inc        = bus.if_valid_i && stall && !bus.flush_i;

  logic [7:0]          aluop_q;
  logic [2:0]          alusel_q;
  logic [REG_AW-1:0]   wd_q;
  logic                wreg_q, illegal_q;
  logic [DATA_W-1:0]   reg1_q, reg2_q, pc_q;
  logic [STALL_CW-1:0] stall_cnt_q;

  // ID/EX register and saturating stall counter
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ex_valid_q  <= 1'b0;
      aluop_q     <= '0;
      alusel_q    <= '0;
      wd_q        <= '0;
      wreg_q      <= 1'b0;
      reg1_q      <= '0;
      reg2_q      <= '0;
      pc_q        <= '0;
      illegal_q   <= 1'b0;
      stall_cnt_q <= '0;
    end else begin
      if (bus.flush_i) begin
        ex_valid_q <= 1'b0;
      end else if (advance) begin
        ex_valid_q <= accept;
        if (accept) begin
          aluop_q   <= dec_aluop;
          alusel_q  <= dec_alusel;
          wd_q      <= dec_wd;
          wreg_q    <= dec_wreg;
          reg1_q    <= op1;
          reg2_q    <= op2;
          pc_q      <= bus.pc_i;
          illegal_q <= dec_illegal;
        end
      end
      if (cnt_inc && (stall_cnt_q != '1)) begin
        stall_cnt_q <= stall_cnt_q + STALL_CW'(1);
      end
    end
  end

  assign bus.ex_valid_o  = ex_valid_q;
  assign bus.aluop_o     = aluop_q;
  assign bus.alusel_o    = alusel_q;
  assign bus.wd_o        = wd_q;
  assign bus.wreg_o      = wreg_q;
  assign bus.reg1_o      = reg1_q;
  assign bus.reg2_o      = reg2_q;
  assign bus.pc_o        = pc_q;
  assign bus.illegal_o   = illegal_q;
  assign bus.stall_cnt_o = stall_cnt_q;

endmodule

// File: tb/tb_id_stage_pipe.sv
// Directed bench for id_stage_pipe; expectations follow ID_FORWARD_EN when it is defined.
module tb_id_stage_pipe;
  localparam int unsigned DATA_W   = 32;
  localparam int unsigned REG_AW   = 5;
  localparam int unsigned STALL_CW = 4;

  localparam logic [31:0] I_ORI  = 32'h342200F0; // ORI  $2,$1,0x00F0
  localparam logic [31:0] I_LUI  = 32'h3C03ABCD; // LUI  $3,0xABCD
  localparam logic [31:0] I_BAD  = 32'hFC000000;
  localparam logic [31:0] I_SUBU = 32'h00223023; // SUBU $6,$1,$2
  localparam logic [31:0] I_SLL  = 32'h00032900; // SLL  $5,$3,4
  localparam logic [31:0] I_OR   = 32'h00432025; // OR   $4,$2,$3

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  id_stage_pipe_if #(.DATA_W(DATA_W), .REG_AW(REG_AW), .STALL_CW(STALL_CW)) bus ();

  id_stage_pipe #(.DATA_W(DATA_W), .REG_AW(REG_AW), .STALL_CW(STALL_CW)) dut (
    .clk  (clk),
    .rst_n(rst_n),
    .bus  (bus.slave)
  );

  logic [DATA_W-1:0] rf [32];
  assign bus.reg1_data_i = rf[bus.reg1_addr_o];
  assign bus.reg2_data_i = rf[bus.reg2_addr_o];

  int checks = 0;
  int errors = 0;
  int exp_cnt = 0;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    bus.if_valid_i   = 1'b0;
    bus.pc_i         = '0;
    bus.inst_i       = '0;
    bus.ex_wreg_i    = 1'b0;
    bus.ex_wd_i      = '0;
    bus.ex_wdata_i   = '0;
    bus.ex_is_load_i = 1'b0;
    bus.mem_wreg_i   = 1'b0;
    bus.mem_wd_i     = '0;
    bus.mem_wdata_i  = '0;
    bus.flush_i      = 1'b0;
    bus.ex_ready_i   = 1'b1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    idle_inputs();
    tick();
    checks++;
    if ({bus.ex_valid_o, bus.aluop_o, bus.alusel_o, bus.wd_o, bus.wreg_o, bus.illegal_o, bus.stall_cnt_o} !== '0) begin
      errors++;
      $display("FAIL reset_ctrl: got v=%b aluop=%h sel=%h wd=%h wreg=%b ill=%b cnt=%0d, want all 0",
               bus.ex_valid_o, bus.aluop_o, bus.alusel_o, bus.wd_o, bus.wreg_o, bus.illegal_o, bus.stall_cnt_o);
    end
    checks++;
    if ({bus.reg1_o, bus.reg2_o, bus.pc_o} !== '0) begin
      errors++;
      $display("FAIL reset_data: got reg1=%h reg2=%h pc=%h, want 0", bus.reg1_o, bus.reg2_o, bus.pc_o);
    end
    rst_n = 1'b1;
    exp_cnt = 0;
  endtask

  task automatic test_ori();
    bus.if_valid_i = 1'b1;
    bus.inst_i = I_ORI;
    bus.pc_i = 32'h100;
    #1;
    checks++;
    if ({bus.id_ready_o, bus.reg1_addr_o, bus.reg2_addr_o} !== {1'b1, 5'd1, 5'd0}) begin
      errors++;
      $display("FAIL ori_addr: got rdy=%b a1=%0d a2=%0d, want 1 1 0", bus.id_ready_o, bus.reg1_addr_o, bus.reg2_addr_o);
    end
    tick();
    checks++;
    if ({bus.ex_valid_o, bus.aluop_o, bus.alusel_o, bus.wd_o, bus.wreg_o, bus.illegal_o} !== {1'b1, 8'h25, 3'd1, 5'd2, 1'b1, 1'b0}) begin
      errors++;
      $display("FAIL ori_ctrl: got v=%b aluop=%h sel=%0d wd=%0d wreg=%b ill=%b, want 1 25 1 2 1 0",
               bus.ex_valid_o, bus.aluop_o, bus.alusel_o, bus.wd_o, bus.wreg_o, bus.illegal_o);
    end
    checks++;
    if ({bus.reg1_o, bus.reg2_o, bus.pc_o} !== {32'h12340000, 32'h000000F0, 32'h100}) begin
      errors++;
      $display("FAIL ori_data: got reg1=%h reg2=%h pc=%h, want 12340000 000000f0 100", bus.reg1_o, bus.reg2_o, bus.pc_o);
    end
  endtask

  task automatic test_lui_illegal();
    bus.inst_i = I_LUI;
    bus.pc_i = 32'h104;
    #1;
    checks++;
    if ({bus.reg1_addr_o, bus.reg2_addr_o} !== 10'd0) begin
      errors++;
      $display("FAIL lui_addr: got a1=%0d a2=%0d, want 0 0", bus.reg1_addr_o, bus.reg2_addr_o);
    end
    tick();
    checks++;
    if ({bus.ex_valid_o, bus.aluop_o, bus.alusel_o, bus.wd_o, bus.wreg_o, bus.reg1_o, bus.reg2_o} !==
        {1'b1, 8'h25, 3'd1, 5'd3, 1'b1, 32'h0, 32'hABCD0000}) begin
      errors++;
      $display("FAIL lui: got v=%b aluop=%h sel=%0d wd=%0d wreg=%b reg1=%h reg2=%h, want 1 25 1 3 1 0 abcd0000",
               bus.ex_valid_o, bus.aluop_o, bus.alusel_o, bus.wd_o, bus.wreg_o, bus.reg1_o, bus.reg2_o);
    end
    bus.inst_i = I_BAD;
    bus.pc_i = 32'h108;
    tick();
    checks++;
    if ({bus.ex_valid_o, bus.wreg_o, bus.illegal_o, bus.aluop_o, bus.alusel_o, bus.pc_o} !==
        {1'b1, 1'b0, 1'b1, 8'h00, 3'd0, 32'h108}) begin
      errors++;
      $display("FAIL illegal: got v=%b wreg=%b ill=%b aluop=%h sel=%0d pc=%h, want 1 0 1 00 0 108",
               bus.ex_valid_o, bus.wreg_o, bus.illegal_o, bus.aluop_o, bus.alusel_o, bus.pc_o);
    end
  endtask

  task automatic test_backpressure();
    bus.ex_ready_i = 1'b0;
    bus.inst_i = I_SUBU;
    bus.pc_i = 32'h10C;
    for (int i = 0; i < 3; i++) begin
      #1;
      checks++;
      if (bus.id_ready_o !== 1'b0) begin
        errors++;
        $display("FAIL bp_ready[%0d]: got %b want 0", i, bus.id_ready_o);
      end
      tick();
      checks++;
      if ({bus.ex_valid_o, bus.illegal_o, bus.pc_o} !== {1'b1, 1'b1, 32'h108}) begin
        errors++;
        $display("FAIL bp_hold[%0d]: got v=%b ill=%b pc=%h want 1 1 108", i, bus.ex_valid_o, bus.illegal_o, bus.pc_o);
      end
    end
    bus.ex_ready_i = 1'b1;
    #1;
    checks++;
    if (bus.id_ready_o !== 1'b1) begin
      errors++;
      $display("FAIL bp_release: got rdy=%b want 1", bus.id_ready_o);
    end
    tick();
    checks++;
    if ({bus.ex_valid_o, bus.aluop_o, bus.alusel_o, bus.wd_o, bus.illegal_o, bus.reg1_o, bus.reg2_o, bus.pc_o} !==
        {1'b1, 8'h23, 3'd3, 5'd6, 1'b0, 32'h12340000, 32'h1111, 32'h10C}) begin
      errors++;
      $display("FAIL subu: got v=%b aluop=%h sel=%0d wd=%0d ill=%b reg1=%h reg2=%h pc=%h",
               bus.ex_valid_o, bus.aluop_o, bus.alusel_o, bus.wd_o, bus.illegal_o, bus.reg1_o, bus.reg2_o, bus.pc_o);
    end
  endtask

  task automatic test_shift();
    bus.inst_i = I_SLL;
    bus.pc_i = 32'h110;
    #1;
    checks++;
    if ({bus.reg1_addr_o, bus.reg2_addr_o} !== {5'd0, 5'd3}) begin
      errors++;
      $display("FAIL sll_addr: got a1=%0d a2=%0d want 0 3", bus.reg1_addr_o, bus.reg2_addr_o);
    end
    tick();
    checks++;
    if ({bus.aluop_o, bus.alusel_o, bus.wd_o, bus.wreg_o, bus.reg1_o, bus.reg2_o} !==
        {8'h00, 3'd2, 5'd5, 1'b1, 32'd4, 32'h2222}) begin
      errors++;
      $display("FAIL sll: got aluop=%h sel=%0d wd=%0d wreg=%b reg1=%h reg2=%h want 00 2 5 1 4 2222",
               bus.aluop_o, bus.alusel_o, bus.wd_o, bus.wreg_o, bus.reg1_o, bus.reg2_o);
    end
  endtask

  task automatic test_raw_alu();
    bus.ex_wreg_i = 1'b1;
    bus.ex_wd_i = 5'd2;
    bus.ex_wdata_i = 32'h55;
    bus.ex_is_load_i = 1'b0;
    bus.inst_i = I_OR;
    bus.pc_i = 32'h114;
`ifdef ID_FORWARD_EN
    #1;
    checks++;
    if (bus.id_ready_o !== 1'b1) begin
      errors++;
      $display("FAIL raw_ready: got %b want 1", bus.id_ready_o);
    end
    tick();
    checks++;
    if ({bus.ex_valid_o, bus.reg1_o, bus.reg2_o, bus.stall_cnt_o} !== {1'b1, 32'h55, 32'h2222, 4'(exp_cnt)}) begin
      errors++;
      $display("FAIL raw_fwd: got v=%b reg1=%h reg2=%h cnt=%0d want 1 55 2222 %0d",
               bus.ex_valid_o, bus.reg1_o, bus.reg2_o, bus.stall_cnt_o, exp_cnt);
    end
`else
    #1;
    checks++;
    if (bus.id_ready_o !== 1'b0) begin
      errors++;
      $display("FAIL raw_ready: got %b want 0", bus.id_ready_o);
    end
    tick();
    exp_cnt++;
    checks++;
    if ({bus.ex_valid_o, bus.pc_o, bus.stall_cnt_o} !== {1'b0, 32'h110, 4'(exp_cnt)}) begin
      errors++;
      $display("FAIL raw_bubble: got v=%b pc=%h cnt=%0d want 0 110 %0d", bus.ex_valid_o, bus.pc_o, bus.stall_cnt_o, exp_cnt);
    end
    bus.ex_wreg_i = 1'b0;
    tick();
    checks++;
    if ({bus.ex_valid_o, bus.aluop_o, bus.reg1_o, bus.reg2_o, bus.stall_cnt_o} !== {1'b1, 8'h25, 32'h1111, 32'h2222, 4'(exp_cnt)}) begin
      errors++;
      $display("FAIL raw_issue: got v=%b aluop=%h reg1=%h reg2=%h cnt=%0d want 1 25 1111 2222 %0d",
               bus.ex_valid_o, bus.aluop_o, bus.reg1_o, bus.reg2_o, bus.stall_cnt_o, exp_cnt);
    end
`endif
    bus.ex_wreg_i = 1'b0;
  endtask

  task automatic test_load_use();
    bus.ex_wreg_i = 1'b1;
    bus.ex_wd_i = 5'd2;
    bus.ex_wdata_i = 32'hDEAD;
    bus.ex_is_load_i = 1'b1;
    bus.inst_i = I_OR;
    bus.pc_i = 32'h118;
    #1;
    checks++;
    if (bus.id_ready_o !== 1'b0) begin
      errors++;
      $display("FAIL lu_ready: got %b want 0", bus.id_ready_o);
    end
    tick();
    exp_cnt++;
    checks++;
    if ({bus.ex_valid_o, bus.stall_cnt_o} !== {1'b0, 4'(exp_cnt)}) begin
      errors++;
      $display("FAIL lu_bubble: got v=%b cnt=%0d want 0 %0d", bus.ex_valid_o, bus.stall_cnt_o, exp_cnt);
    end
    bus.ex_wreg_i = 1'b0;
    bus.ex_is_load_i = 1'b0;
    bus.mem_wreg_i = 1'b1;
    bus.mem_wd_i = 5'd2;
    bus.mem_wdata_i = 32'h77;
`ifdef ID_FORWARD_EN
    tick();
    checks++;
    if ({bus.ex_valid_o, bus.reg1_o, bus.pc_o, bus.stall_cnt_o} !== {1'b1, 32'h77, 32'h118, 4'(exp_cnt)}) begin
      errors++;
      $display("FAIL lu_mem_fwd: got v=%b reg1=%h pc=%h cnt=%0d want 1 77 118 %0d",
               bus.ex_valid_o, bus.reg1_o, bus.pc_o, bus.stall_cnt_o, exp_cnt);
    end
`else
    tick();
    exp_cnt++;
    checks++;
    if ({bus.ex_valid_o, bus.stall_cnt_o} !== {1'b0, 4'(exp_cnt)}) begin
      errors++;
      $display("FAIL lu_mem_stall: got v=%b cnt=%0d want 0 %0d", bus.ex_valid_o, bus.stall_cnt_o, exp_cnt);
    end
    bus.mem_wreg_i = 1'b0;
    tick();
    checks++;
    if ({bus.ex_valid_o, bus.reg1_o, bus.pc_o} !== {1'b1, 32'h1111, 32'h118}) begin
      errors++;
      $display("FAIL lu_issue: got v=%b reg1=%h pc=%h want 1 1111 118", bus.ex_valid_o, bus.reg1_o, bus.pc_o);
    end
`endif
    bus.mem_wreg_i = 1'b0;
  endtask

  task automatic test_flush();
    bus.ex_wreg_i = 1'b1;
    bus.ex_wd_i = 5'd3;
    bus.ex_is_load_i = 1'b1;
    bus.inst_i = I_OR;
    bus.pc_i = 32'h11C;
    bus.flush_i = 1'b1;
    #1;
    checks++;
    if (bus.id_ready_o !== 1'b0) begin
      errors++;
      $display("FAIL flush_ready: got %b want 0", bus.id_ready_o);
    end
    tick();
    checks++;
    if ({bus.ex_valid_o, bus.stall_cnt_o} !== {1'b0, 4'(exp_cnt)}) begin
      errors++;
      $display("FAIL flush_stall: got v=%b cnt=%0d want 0 %0d", bus.ex_valid_o, bus.stall_cnt_o, exp_cnt);
    end
    bus.flush_i = 1'b0;
    bus.if_valid_i = 1'b0;
    bus.ex_wreg_i = 1'b0;
    bus.ex_is_load_i = 1'b0;
    tick();
    checks++;
    if ({bus.ex_valid_o, bus.pc_o} !== {1'b0, 32'h118}) begin
      errors++;
      $display("FAIL flush_drop: got v=%b pc=%h want 0 118", bus.ex_valid_o, bus.pc_o);
    end
    bus.if_valid_i = 1'b1;
    bus.inst_i = I_ORI;
    bus.pc_i = 32'h120;
    tick();
    bus.ex_ready_i = 1'b0;
    bus.flush_i = 1'b1;
    tick();
    checks++;
    if ({bus.ex_valid_o, bus.pc_o} !== {1'b0, 32'h120}) begin
      errors++;
      $display("FAIL flush_held: got v=%b pc=%h want 0 120", bus.ex_valid_o, bus.pc_o);
    end
    bus.flush_i = 1'b0;
    bus.ex_ready_i = 1'b1;
  endtask

  task automatic test_saturate();
    bus.ex_wreg_i = 1'b1;
    bus.ex_wd_i = 5'd2;
    bus.ex_is_load_i = 1'b1;
    bus.inst_i = I_OR;
    bus.pc_i = 32'h124;
    for (int i = 0; i < 20; i++) begin
      tick();
      if (exp_cnt < 15) exp_cnt++;
      checks++;
      if (bus.stall_cnt_o !== 4'(exp_cnt)) begin
        errors++;
        $display("FAIL sat_cnt[%0d]: got %0d want %0d", i, bus.stall_cnt_o, exp_cnt);
      end
    end
  endtask

  task automatic test_reset_mid_stall();
    #2;
    rst_n = 1'b0;
    #1;
    checks++;
    if ({bus.ex_valid_o, bus.stall_cnt_o, bus.pc_o, bus.reg1_o, bus.aluop_o} !== '0) begin
      errors++;
      $display("FAIL mid_reset: got v=%b cnt=%0d pc=%h reg1=%h aluop=%h want all 0",
               bus.ex_valid_o, bus.stall_cnt_o, bus.pc_o, bus.reg1_o, bus.aluop_o);
    end
    tick();
    rst_n = 1'b1;
    tick();
    checks++;
    if ({bus.ex_valid_o, bus.stall_cnt_o} !== {1'b0, 4'd1}) begin
      errors++;
      $display("FAIL restart_cnt: got v=%b cnt=%0d want 0 1", bus.ex_valid_o, bus.stall_cnt_o);
    end
    idle_inputs();
  endtask

  initial begin
    for (int i = 0; i < 32; i++) rf[i] = '0;
    rf[1] = 32'h12340000;
    rf[2] = 32'h00001111;
    rf[3] = 32'h00002222;
    test_reset();
    test_ori();
    test_lui_illegal();
    test_backpressure();
    test_shift();
    test_raw_alu();
    test_load_use();
    test_flush();
    test_saturate();
    test_reset_mid_stall();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

// File: doc/id_stage_pipe.md
Name: id_stage_pipe

Overview:
- Parametrised successor to the combinational MIPS decode stage.
- Decodes logic, shift and add/sub instructions and reads two register-file ports.
- Resolves RAW hazards against the EX and MEM stages, by stalling or by forwarding.
- Drives a registered ID/EX pipeline register toward EX with a valid/ready handshake, plus flush and a saturating stall counter.

Parameters:
- DATA_W, 32, datapath/register width.
- REG_AW, 5, register address width.
- STALL_CW, 16, stall counter width.

Ports:
- clk  in  1  clock.
- rst_n  in  1  reset.
- if_valid_i  in  1  IF presents an instruction.
- pc_i  in  DATA_W  instruction PC.
- inst_i  in  32  instruction word.
- id_ready_o  out  1  ID accepts the instruction this cycle.
- reg1_addr_o / reg2_addr_o  out  REG_AW  regfile read addresses (combinational).
- reg1_data_i / reg2_data_i  in  DATA_W  regfile read data (combinational).
- ex_wreg_i, ex_wd_i, ex_wdata_i, ex_is_load_i  in  1/REG_AW/DATA_W/1  EX-stage writer info.
- mem_wreg_i, mem_wd_i, mem_wdata_i  in  1/REG_AW/DATA_W  MEM-stage writer info.
- flush_i  in  1  kill the instruction in ID and ID/EX.
- ex_valid_o  out  1  ID/EX register holds a valid instruction.
- ex_ready_i  in  1  EX consumes ID/EX this cycle.
- aluop_o, alusel_o, wd_o, wreg_o, reg1_o, reg2_o, pc_o  out  8/3/REG_AW/1/DATA_W/DATA_W/DATA_W  registered decode results.
- illegal_o  out  1  registered: instruction was undecodable (issued as NOP).
- stall_cnt_o  out  STALL_CW  hazard stall cycles, saturating.

Behaviour:
- Reset: clock is clk; reset is asynchronous and active-low. While rst_n=0, every registered output is 0 (ex_valid_o, aluop_o, alusel_o, wd_o, wreg_o, reg1_o, reg2_o, pc_o, illegal_o, stall_cnt_o).
- Decode is combinational from inst_i; rs=[25:21], rt=[20:16], rd=[15:11], sa=[10:6].
- I-type (wd=rt, operand2=imm):
  - ORI 0x0D, ANDI 0x0C, XORI 0x0E: imm zero-extended.
  - LUI 0x0F: operand1=0, operand2={imm,16'h0}.
- SPECIAL op 0x00 (wd=rd), by funct:
  - AND 0x24, OR 0x25, XOR 0x26, NOR 0x27, ADDU 0x21, SUBU 0x23.
  - SLL 0x00, SRL 0x02, SRA 0x03: operand1=zero-extended sa, operand2=rt.
- aluop_o = funct for SPECIAL; ORI→0x25, ANDI→0x24, XORI→0x26, LUI→0x25.
- alusel_o: NOP=0, LOGIC=1, SHIFT=2, ARITH=3.
- Any other opcode/funct: wreg=0, aluop=0, alusel=0, illegal=1; still issued.
- Reading: a source operand is read only when the instruction uses it. Unread address ports drive 0.
- Hazard: a used source s≠0 matches ex_wd_i (with ex_wreg_i) or mem_wd_i (with mem_wreg_i). Register 0 never hazards.
- Stall condition (without ID_FORWARD_EN): any hazard.
- Source operand value (without ID_FORWARD_EN): regfile data.
- Handshake:
  - advance = (!ex_valid_o || ex_ready_i).
  - id_ready_o = advance && !stall && !flush_i.
  - On advance: ex_valid_o ← if_valid_i && id_ready_o, and payload loads when that is 1.
  - If advance && (stall || !if_valid_i): ex_valid_o←0 (bubble); payload holds.
  - If !advance: all outputs hold.
- flush_i: next edge ex_valid_o←0 and the ID instruction is not accepted. Flush has priority over advance and stall.
- stall_cnt_o increments each cycle with if_valid_i && stall && !flush_i. It saturates at all-ones and never wraps.
- Reset mid-stall: outputs clear immediately and the counter returns to 0.

Optional Feature:
- Macro ID_FORWARD_EN.
- When defined:
  - Operand source priority: EX match > MEM match > regfile.
  - Stall only on load-use: ex_is_load_i && ex_wreg_i && ex_wd_i matches a used source.
  - A MEM-only match never stalls.
- When undefined: the stall-on-any-hazard behaviour above, with no forwarding muxes.

Test Plan:
- Reset then ORI $2,$1,0x00F0 with reg1_data=0x1234_0000 → 1 cycle later ex_valid=1, aluop=0x25, alusel=1, wd=2, wreg=1, reg1_o=0x12340000, reg2_o=0x000000F0.
- LUI $3,0xABCD → reg1_o=0, reg2_o=0xABCD0000. Then word 0xFC000000 → illegal_o=1, wreg_o=0, ex_valid_o=1.
- ex_ready_i=0 for 3 cycles with ex_valid_o=1 → id_ready_o=0 and outputs stable. Release → next instruction loads on the following edge.
- OR $4,$2,$3 with ex_wd=2, ex_wreg=1, ex_wdata=0x55, ex_is_load=0:
  - without macro: 1-cycle bubble, stall_cnt=1;
  - with macro: no stall, reg1_o=0x55.
- Same OR with ex_is_load=1 → stall in both builds while EX holds the load. With macro, when the match moves to MEM with mem_wdata=0x77 → reg1_o=0x77.
- flush_i during a stall → ex_valid_o=0 next cycle, instruction dropped, stall_cnt not incremented. Also: force stall_cnt to all-ones, stall again → value holds.
